multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RV32I core. It sequences one shared ALU, one unified instruction/data memory port and the PC/IR/register-file write enables across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states. It drives the 2-bit alu_op to the existing combinational ALU-control decode and handles the memory ready handshake, bus timeouts and illegal opcodes.

Parameters:
TIMEOUT, 16, consecutive not-ready memory cycles before a bus-timeout trap; 0 disables the timeout.
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
op  in  7  IR[6:0] opcode
funct3  in  3  IR[14:12]
zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory access completes this cycle
mem_req  out  1  memory access request
mem_we  out  1  store strobe, valid only with mem_req
adr_src  out  1  0 = PC, 1 = ALUOut
ir_we  out  1  latch fetched word into IR and PC into OldPC
pc_we  out  1  PC write enable
reg_we  out  1  register file write
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 reg
alu_src_b  out  2  00 rs2 reg, 01 imm, 10 const 4
alu_op  out  2  00 add, 01 sub, 10 decode funct3/funct7
result_src  out  2  00 ALUOut, 01 memory data reg, 10 ALU result
retire  out  1  one-cycle pulse per completed instruction
trap  out  2  00 none, 01 illegal instruction, 10 bus timeout; sticky

Behaviour:
- Outputs are combinational from state (Moore). Exceptions: mem_ready-qualified enables and the BRANCH pc_we, which also depend on inputs (Mealy).
- Reset: while rst_n is low, all enables, mem_req and retire are forced to 0. Next state is FETCH, the wait counter is 0 and trap is 00. Reset in any state, including mid-access, aborts the access.
- All outputs not listed for a state are 0 / 00.
- FETCH: mem_req=1, adr_src=0.
  - When mem_ready=1: ir_we=1, pc_we=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10 (PC+4); go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 with funct3 0 or 1 -> BRANCH
  - anything else -> TRAP with cause 01
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state is MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. On mem_ready go to MEMWB.
- MEMWB: result_src=01, reg_we=1, retire=1; go to FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready: retire=1, go to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10; go to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10; go to ALUWB.
- ALUWB: result_src=00, reg_we=1, retire=1; go to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_we=1 (PC <= target); go to ALUWB, which writes OldPC+4 to rd.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_we = zero XOR funct3[0], retire=1; go to FETCH.
- TRAP: trap holds its cause, all enables 0, no retire. Stays in TRAP until reset.
- Wait counter:
  - Cleared on entering any request state and whenever mem_ready=1.
  - Increments each cycle that mem_req=1 and mem_ready=0, saturating at all-ones.
  - If TIMEOUT!=0 and the counter equals TIMEOUT-1 while mem_ready=0, the next state is TRAP with cause 10.
  - mem_ready=1 in that same cycle wins: the access completes and no trap is raised.
- Zero-wait memory: mem_ready=1 on the first request cycle completes the access in that cycle.
- Instruction latency with zero-wait memory, measured from FETCH entry to retire:
  - add/addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne: 3 cycles
  - jal: 4 cycles

Test Plan:
- Reset, then rst_n=1 with mem_ready tied to 1: cycle 0 is FETCH with mem_req=1, ir_we=1, pc_we=1, alu_src_b=10. Drive op=0110011: DECODE -> EXECR (alu_op=10) -> ALUWB (reg_we=1, retire=1) -> FETCH.
- Load, op=0000011, with mem_ready low for 3 cycles in MEMREAD: mem_req held for 4 cycles with adr_src=1, then MEMWB with result_src=01, reg_we=1; exactly one retire pulse.
- Branch, op=1100011: funct3=000 with zero=1 gives pc_we=1; funct3=001 with zero=1 gives pc_we=0; funct3=100 gives trap=01 after DECODE with no retire.
- Timeout with TIMEOUT=16 and mem_ready held 0 in FETCH: trap=10 after 16 request cycles and held afterwards. A repeat run with mem_ready=1 on the 16th cycle completes the fetch with no trap.
- Illegal op=1111111: trap=01, all enables stay 0 for 20 cycles. Then rst_n=0 for 1 cycle: state is FETCH, trap=00.
- rst_n pulsed low during MEMWRITE wait: mem_we and mem_req are 0 during reset and the FSM restarts in FETCH. jal: ALUWB writes with result_src=00, preceded by pc_we=1 in the JAL state.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and the datapath plus memory.
//   master : controller side. It reads the IR fields, the ALU zero flag and mem_ready.
//            It drives the memory request, write enables, mux selects, retire and trap.
//   slave  : datapath/memory side, with the directions mirrored.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
    logic [1:0] trap;

    modport master (
        input  op, funct3, zero, mem_ready,
        output mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
               alu_src_a, alu_src_b, alu_op, result_src, retire, trap
    );

    modport slave (
        output op, funct3, zero, mem_ready,
        input  mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
               alu_src_a, alu_src_b, alu_op, result_src, retire, trap
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core.
// It sequences the shared ALU, the unified memory port and the PC/IR/register-file enables.
// The state flow is FETCH, DECODE, then an execute/memory step, then writeback.
// A wait counter traps the core when a bus access hangs.
// Illegal opcodes also trap, and the core then stays in the trap state until reset.
//   clk   : core clock, rising edge
//   rst_n : synchronous active-low reset; also gates all enables low while asserted
//   bus   : multicycle_ctrl_if.master (IR fields, zero, mem_ready in; controls out)
// Parameters:
//   TIMEOUT : consecutive not-ready request cycles before a bus-timeout trap (0 = off)
//   CNT_W   : wait counter width, 2**CNT_W must exceed TIMEOUT
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
        StExecR, StExecI, StAluWb, StJal, StBranch, StTrap
    } state_e;

    localparam logic [1:0] TrapNone    = 2'b00;
    localparam logic [1:0] TrapIllegal = 2'b01;
    localparam logic [1:0] TrapBus     = 2'b10;

    // Last counter value that is still tolerated before the timeout fires.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         trap_q, trap_d;
    logic               is_req;
    logic               timeout_hit;

    assign is_req = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
    // mem_ready in the same cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT != 0) && is_req && !bus.mem_ready && (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            trap_q  <= TrapNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        cnt_d   = '0;
        // Every request state is entered either from a non-request state or on mem_ready.
        // Both paths leave the counter at zero, so entry-clear needs no separate term.
        if (is_req && !bus.mem_ready) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
        unique case (state_q)
            StFetch:    if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                case (bus.op)
                    7'b0000011, 7'b0100011: state_d = StMemAdr;
                    7'b0110011:             state_d = StExecR;
                    7'b0010011:             state_d = StExecI;
                    7'b1101111:             state_d = StJal;
                    7'b1100011: begin
                        if (bus.funct3[2:1] == 2'b00) begin
                            state_d = StBranch;
                        end else begin
                            state_d = StTrap;
                            trap_d  = TrapIllegal;
                        end
                    end
                    default: begin
                        state_d = StTrap;
                        trap_d  = TrapIllegal;
                    end
                endcase
            end
            StMemAdr:   state_d = (bus.op == 7'b0000011) ? StMemRead : StMemWrite;
            StMemRead:  if (bus.mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (bus.mem_ready) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StJal:      state_d = StAluWb;
            StBranch:   state_d = StFetch;
            StTrap:     state_d = StTrap;
            default:    state_d = StFetch;
        endcase
        if (timeout_hit) begin
            state_d = StTrap;
            trap_d  = TrapBus;
        end
    end

    logic       mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, retire;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        retire     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                end
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_we     = 1'b1;
                retire     = 1'b1;
            end
            StMemWrite: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                retire  = bus.mem_ready;
            end
            StExecR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            StAluWb: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            StJal: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_we     = 1'b1;
            end
            StBranch: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                // funct3[0] selects bne: take the branch when zero disagrees with it.
                pc_we     = bus.zero ^ bus.funct3[0];
                retire    = 1'b1;
            end
            StTrap: ;
            default: ;
        endcase
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
            retire  = 1'b0;
        end
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.adr_src    = adr_src;
    assign bus.ir_we      = ir_we;
    assign bus.pc_we      = pc_we;
    assign bus.reg_we     = reg_we;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.result_src = result_src;
    assign bus.retire     = retire;
    assign bus.trap       = trap_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// The reference model expands each instruction into its expected per-cycle output trace.
// It builds the trace from the instruction class and the chosen memory wait counts.
module tb_multicycle_ctrl;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;
    localparam int KR = 0, KI = 1, KLoad = 2, KStore = 3, KBr = 4, KJal = 5, KIll = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, adr_src, ir_we, pc_we, reg_we;
        logic [1:0] a, b, alu_op, res;
        logic       retire;
        logic [1:0] trap;
    } out_t;

    typedef struct {
        bit    rdy;
        bit    zero;
        out_t  exp;
        string tag;
    } cyc_t;

    cyc_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic out_t observe();
        out_t o;
        o.mem_req = bus.mem_req;  o.mem_we = bus.mem_we;  o.adr_src = bus.adr_src;
        o.ir_we   = bus.ir_we;    o.pc_we  = bus.pc_we;   o.reg_we  = bus.reg_we;
        o.a       = bus.alu_src_a; o.b = bus.alu_src_b;   o.alu_op  = bus.alu_op;
        o.res     = bus.result_src; o.retire = bus.retire; o.trap   = bus.trap;
        return o;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'h03:   return KLoad;
            7'h23:   return KStore;
            7'h33:   return KR;
            7'h13:   return KI;
            7'h6F:   return KJal;
            7'h63:   return (f3 <= 3'd1) ? KBr : KIll;
            default: return KIll;
        endcase
    endfunction

    task automatic push(input bit rdy, input bit z, input out_t e, input string tag);
        cyc_t c;
        c.rdy = rdy; c.zero = z; c.exp = e; c.tag = tag;
        q.push_back(c);
    endtask

    task automatic m_trap(input logic [1:0] cause, input int n);
        out_t e = '0;
        e.trap = cause;
        for (int i = 0; i < n; i++) push(rb(), rb(), e, "trap_hold");
    endtask

    // w not-ready cycles before the access completes; w >= TIMEOUT ends in a bus trap.
    task automatic m_wait(input int w, input out_t e, input string tag, input int ntrap,
                          output bit to);
        int n = (w < TIMEOUT) ? w : TIMEOUT;
        for (int i = 0; i < n; i++) push(1'b0, rb(), e, tag);
        to = (w >= TIMEOUT);
        if (to) m_trap(2'b10, ntrap);
    endtask

    task automatic m_instr(input int kind, input int wf, input int wm, input bit z,
                           input logic [2:0] f3, input int ntrap, output bit trapped);
        out_t e;
        bit   to;
        trapped = 1'b0;
        e = '0; e.mem_req = 1'b1;
        m_wait(wf, e, "fetch_wait", ntrap, to);
        if (to) begin trapped = 1'b1; return; end
        e.ir_we = 1'b1; e.pc_we = 1'b1; e.b = 2'b10; e.res = 2'b10;
        push(1'b1, rb(), e, "fetch");
        e = '0; e.a = 2'b01; e.b = 2'b01;
        push(rb(), rb(), e, "decode");
        case (kind)
            KR, KI: begin
                e = '0; e.a = 2'b10; e.b = (kind == KI) ? 2'b01 : 2'b00; e.alu_op = 2'b10;
                push(rb(), rb(), e, "exec");
                e = '0; e.reg_we = 1'b1; e.retire = 1'b1;
                push(rb(), rb(), e, "alu_wb");
            end
            KLoad, KStore: begin
                e = '0; e.a = 2'b10; e.b = 2'b01;
                push(rb(), rb(), e, "mem_adr");
                e = '0; e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_we = (kind == KStore);
                m_wait(wm, e, "mem_wait", ntrap, to);
                if (to) begin trapped = 1'b1; return; end
                e.retire = (kind == KStore);
                push(1'b1, rb(), e, "mem_done");
                if (kind == KLoad) begin
                    e = '0; e.res = 2'b01; e.reg_we = 1'b1; e.retire = 1'b1;
                    push(rb(), rb(), e, "mem_wb");
                end
            end
            KBr: begin
                e = '0; e.a = 2'b10; e.alu_op = 2'b01; e.pc_we = z ^ f3[0]; e.retire = 1'b1;
                push(rb(), z, e, "branch");
            end
            KJal: begin
                e = '0; e.a = 2'b01; e.b = 2'b10; e.pc_we = 1'b1;
                push(rb(), rb(), e, "jal");
                e = '0; e.reg_we = 1'b1; e.retire = 1'b1;
                push(rb(), rb(), e, "jal_wb");
            end
            default: begin
                m_trap(2'b01, ntrap);
                trapped = 1'b1;
            end
        endcase
    endtask

    task automatic run_q();
        cyc_t c;
        out_t got;
        while (q.size() > 0) begin
            c = q.pop_front();
            bus.mem_ready = c.rdy;
            bus.zero      = c.zero;
            @(negedge clk);
            got = observe();
            vectors++;
            if (got !== c.exp) begin
                miscompares++;
                $display("FAIL %s: got %h, expected %h", c.tag, got, c.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int wf,
                             input int wm, input bit z, input int ntrap, output bit trapped);
        bus.op     = op;
        bus.funct3 = f3;
        m_instr(classify(op, f3), wf, wm, z, f3, ntrap, trapped);
        run_q();
    endtask

    task automatic do_reset(input int n, input bit rdy);
        logic [5:0] en;
        rst_n = 1'b0;
        bus.mem_ready = rdy;
        bus.zero = rb();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en = {bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.reg_we, bus.retire};
            vectors++;
            if (en !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_enables: got %b, expected 000000", en);
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit tr;
        do_reset(2, 1'b1);
        run_instr(7'h33, 3'd0, 0, 0, 1'b0, 3, tr);
    endtask

    task automatic test_load_wait();
        bit tr;
        run_instr(7'h03, 3'd2, 0, 3, 1'b0, 3, tr);
    endtask

    task automatic test_branch();
        bit tr;
        run_instr(7'h63, 3'b000, 0, 0, 1'b1, 3, tr);
        run_instr(7'h63, 3'b001, 0, 0, 1'b1, 3, tr);
        run_instr(7'h63, 3'b001, 1, 0, 1'b0, 3, tr);
        run_instr(7'h63, 3'b100, 0, 0, 1'b1, 4, tr);
        do_reset(1, rb());
    endtask

    task automatic test_timeout();
        bit tr;
        run_instr(7'h33, 3'd0, TIMEOUT, 0, 1'b0, 6, tr);
        do_reset(1, 1'b0);
        run_instr(7'h33, 3'd0, TIMEOUT - 1, 0, 1'b0, 3, tr);
        run_instr(7'h03, 3'd0, 0, TIMEOUT - 1, 1'b0, 3, tr);
        run_instr(7'h23, 3'd0, 0, TIMEOUT, 1'b0, 4, tr);
        do_reset(1, rb());
    endtask

    task automatic test_illegal();
        bit tr;
        run_instr(7'h7F, 3'd0, 0, 0, 1'b0, 20, tr);
        do_reset(1, 1'b1);
        run_instr(7'h13, 3'd5, 0, 0, 1'b0, 3, tr);
    endtask

    task automatic test_store_reset();
        bit tr;
        out_t e;
        bus.op = 7'h23;
        bus.funct3 = 3'd2;
        e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.b = 2'b10; e.res = 2'b10;
        push(1'b1, 1'b0, e, "st_fetch");
        e = '0; e.a = 2'b01; e.b = 2'b01;
        push(1'b0, 1'b0, e, "st_decode");
        e = '0; e.a = 2'b10; e.b = 2'b01;
        push(1'b0, 1'b0, e, "st_mem_adr");
        e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.adr_src = 1'b1;
        push(1'b0, 1'b0, e, "st_wait");
        push(1'b0, 1'b0, e, "st_wait");
        run_q();
        do_reset(1, 1'b0);
        run_instr(7'h6F, 3'd0, 0, 0, 1'b0, 3, tr);
    endtask

    task automatic test_random();
        logic [6:0] legal [6];
        logic [6:0] op;
        logic [2:0] f3;
        int         sel, wf, wm;
        bit         tr;
        legal = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63};
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 19);
            if (sel < 18) begin
                op = legal[sel % 6];
            end else begin
                do op = 7'($urandom_range(0, 127));
                while (classify(op, 3'd0) != KIll);
            end
            f3 = 3'($urandom_range(0, 7));
            if (op == 7'h63 && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
            wf = ($urandom_range(0, 24) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT)
                                              : $urandom_range(0, 3);
            wm = ($urandom_range(0, 24) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT)
                                              : $urandom_range(0, 3);
            run_instr(op, f3, wf, wm, rb(), 3, tr);
            if (tr) do_reset(1, rb());
        end
    endtask

    initial begin
        bus.op = 7'h0;
        bus.funct3 = 3'h0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_wait();
        test_branch();
        test_timeout();
        test_illegal();
        test_store_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
